// File: rtl/drum_note_scroller.sv
// drum_note_scroller: turns a 4-lane random pattern into falling drum notes.
// Notes scroll from row DEPTH-1 (spawn) down to row 0 (hit row). Pad strikes
// are scored against row 0. The block also tracks score, combo and misses,
// and runs the IDLE/PLAY/PAUSE/OVER game FSM. Every output is registered.
module drum_note_scroller #(
  parameter int DEPTH      = 8,
  parameter int SPAWN_DIV  = 4,
  parameter int MAX_MISSES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               tick,
  input  logic [3:0]         rand_in,
  input  logic [3:0]         hits,
  output logic               rand_take,
  output logic [4*DEPTH-1:0] rows_out,
  output logic [15:0]        score,
  output logic [7:0]         combo,
  output logic [3:0]         misses,
  output logic [1:0]         state,
  output logic               game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] SPAWN_LAST = 4'(SPAWN_DIV - 1);
  localparam logic [4:0] MISS_LIM   = 5'(MAX_MISSES);

  state_t cur, nxt;

  // Packed so that row i lands on bits [4i+3:4i] of rows_out.
  logic [DEPTH-1:0][3:0] rows_q;
  logic [3:0]            spawn_cnt;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    pop4 = {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  logic [3:0]  row0, good, row0_left, residual;
  logic        wrong, miss_hit;
  logic [2:0]  good_n, miss_n;
  logic [3:0]  pts;
  logic [16:0] score_sum;
  logic [15:0] score_upd;
  logic [8:0]  combo_sum;
  logic [7:0]  combo_inc, combo_upd;
  logic [4:0]  miss_sum;
  logic [3:0]  misses_upd;

  // Scoring for one PLAY cycle. Hits are judged against row 0 before any
  // shift, so a matched note can never also be counted as a miss.
  always_comb begin
    row0      = rows_q[0];
    good      = hits & row0;
    wrong     = |(hits & ~row0);
    row0_left = row0 & ~hits;
    good_n    = pop4(good);
    // Double points once the combo (pre-update) has reached 8.
    pts       = (combo >= 8'd8) ? {good_n, 1'b0} : {1'b0, good_n};
    score_sum = {1'b0, score} + {13'b0, pts};
    score_upd = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    combo_sum = {1'b0, combo} + {6'b0, good_n};
    combo_inc = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    // Only a tick pushes row 0 out; whatever is left unhit is a miss.
    residual  = tick ? row0_left : 4'b0;
    miss_n    = pop4(residual);
    miss_sum  = {1'b0, misses} + {2'b0, miss_n};
    miss_hit  = (miss_sum >= MISS_LIM);
    misses_upd = miss_hit ? MISS_LIM[3:0] : miss_sum[3:0];
    // A wrong strike or a missed note breaks the combo, overriding any gain.
    combo_upd = (wrong || (|residual)) ? 8'd0 : combo_inc;
  end

  // Game state register.
  always_ff @(posedge clk) begin
    if (reset) cur <= S_IDLE;
    else       cur <= nxt;
  end

  // Next-state logic: start > pause > tick/hits; miss limit wins over pause.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (start) nxt = S_PLAY;
      S_PLAY: begin
        if (miss_hit)   nxt = S_OVER;
        else if (pause) nxt = S_PAUSE;
      end
      S_PAUSE: if (pause) nxt = S_PLAY;
      S_OVER:  if (start) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Scroll buffer, counters and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q    <= '0;
      spawn_cnt <= 4'd0;
      score     <= 16'd0;
      combo     <= 8'd0;
      misses    <= 4'd0;
      rand_take <= 1'b0;
      game_over <= 1'b0;
    end else begin
      rand_take <= 1'b0;
      game_over <= (nxt == S_OVER);
      case (cur)
        S_IDLE: begin
          rows_q    <= '0;
          spawn_cnt <= 4'd0;
          score     <= 16'd0;
          combo     <= 8'd0;
          misses    <= 4'd0;
        end
        S_PLAY: begin
          score  <= score_upd;
          combo  <= combo_upd;
          misses <= misses_upd;
          if (tick) begin
            for (int i = 0; i < DEPTH - 1; i++) rows_q[i] <= rows_q[i+1];
            rows_q[DEPTH-1] <= (spawn_cnt == 4'd0) ? rand_in : 4'b0;
            rand_take       <= (spawn_cnt == 4'd0);
            spawn_cnt       <= (spawn_cnt == SPAWN_LAST) ? 4'd0 : spawn_cnt + 4'd1;
          end else begin
            rows_q[0] <= row0_left;
          end
        end
        S_PAUSE: ;
        S_OVER: begin
          // Board holds for the final display; start wipes it on the way out.
          if (start) begin
            rows_q    <= '0;
            spawn_cnt <= 4'd0;
            score     <= 16'd0;
            combo     <= 8'd0;
            misses    <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rows_out = rows_q;
  assign state    = cur;

endmodule

// File: tb/tb_drum_note_scroller.sv
// Directed bench for drum_note_scroller (DEPTH=8, SPAWN_DIV=4, MAX_MISSES=15).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled there too.
module tb_drum_note_scroller;

  logic        clk = 1'b0;
  logic        reset, start, pause, tick;
  logic [3:0]  rand_in, hits;
  logic        rand_take;
  logic [31:0] rows_out;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [3:0]  misses;
  logic [1:0]  state;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  drum_note_scroller #(.DEPTH(8), .SPAWN_DIV(4), .MAX_MISSES(15)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .tick(tick),
    .rand_in(rand_in), .hits(hits), .rand_take(rand_take), .rows_out(rows_out),
    .score(score), .combo(combo), .misses(misses), .state(state),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; strobes drop right after the edge that consumed them.
  task automatic cyc();
    @(posedge clk);
    #1;
    tick = 1'b0; hits = 4'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin tick = 1'b1; cyc(); end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_rows"},  rows_out, 32'h0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_combo"}, 32'(combo), 32'd0);
    chk({tag, "_miss"},  32'(misses), 32'd0);
    chk({tag, "_take"},  32'(rand_take), 32'd0);
    chk({tag, "_over"},  32'(game_over), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; tick = 1'b0;
    rand_in = 4'b0; hits = 4'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk_zero("reset");

    // Start a game, scroll 1010 for 8 ticks: spawns on ticks 1 and 5.
    start = 1'b1; cyc();
    chk("start_state", 32'(state), 32'd1);
    rand_in = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      tick = 1'b1; cyc();
      chk($sformatf("take_t%0d", k), 32'(rand_take), 32'((k == 1) || (k == 5)));
      if (k == 7) chk("rows_t7", rows_out, 32'h00A0_00A0);
    end
    chk("rows_t8", rows_out, 32'h000A_000A);

    // Clean two-note hit, no tick.
    hits = 4'b1010; cyc();
    chk("hit2_rows",  rows_out, 32'h000A_0000);
    chk("hit2_score", 32'(score), 32'd2);
    chk("hit2_combo", 32'(combo), 32'd2);
    chk("hit2_miss",  32'(misses), 32'd0);

    // Spawn 0011 on tick 9; after tick 12 row0=1010, row4=0011.
    rand_in = 4'b0011; tick = 1'b1; cyc();
    chk("take_t9", 32'(rand_take), 32'd1);
    ticks(3);
    chk("rows_t12", rows_out, 32'h0003_000A);

    // Partial hit during a tick: one point, one miss, combo broken.
    rand_in = 4'b0001; hits = 4'b1000; tick = 1'b1; cyc();
    chk("part_score", 32'(score), 32'd3);
    chk("part_combo", 32'(combo), 32'd0);
    chk("part_miss",  32'(misses), 32'd1);
    chk("part_rows",  rows_out, 32'h1000_3000);

    // 0011 arrives at row 0 after tick 16.
    rand_in = 4'b1111; ticks(3);
    chk("rows_t16", rows_out, 32'h0001_0003);
    hits = 4'b0011; cyc();
    chk("h0011_score", 32'(score), 32'd5);
    chk("h0011_combo", 32'(combo), 32'd2);

    // Tick 17 spawns 1111; 0001 (tick 13) is hit after tick 20.
    tick = 1'b1; cyc();
    rand_in = 4'b0001; ticks(3);
    hits = 4'b0001; cyc();
    chk("h0001_score", 32'(score), 32'd6);
    chk("h0001_combo", 32'(combo), 32'd3);

    // 1111 (tick 17) hit after tick 24.
    ticks(4);
    chk("rows_t24", rows_out, 32'h0001_000F);
    hits = 4'b1111; cyc();
    chk("h1111_score", 32'(score), 32'd10);
    chk("h1111_combo", 32'(combo), 32'd7);

    // Combo 7 -> 8 at single points.
    ticks(4);
    hits = 4'b0001; cyc();
    chk("c8_score", 32'(score), 32'd11);
    chk("c8_combo", 32'(combo), 32'd8);

    // With combo 8 the next note is worth double.
    rand_in = 4'b1111; ticks(4);
    hits = 4'b0001; cyc();
    chk("dbl_score", 32'(score), 32'd13);
    chk("dbl_combo", 32'(combo), 32'd9);
    chk("dbl_rows",  rows_out, 32'h000F_0000);

    // Wrong strike on an empty row 0.
    hits = 4'b1000; cyc();
    chk("wrong_combo", 32'(combo), 32'd0);
    chk("wrong_score", 32'(score), 32'd13);

    // Let 1111 rows fall unhit: 1 -> 5 -> 9 -> 13 -> 15 (saturated).
    ticks(16);
    chk("t48_miss",  32'(misses), 32'd13);
    chk("t48_state", 32'(state), 32'd1);
    tick = 1'b1; cyc();
    chk("t49_miss",  32'(misses), 32'd15);
    chk("t49_state", 32'(state), 32'd3);
    chk("t49_over",  32'(game_over), 32'd1);
    chk("t49_take",  32'(rand_take), 32'd1);
    chk("t49_rows",  rows_out, 32'hF000_F000);

    // OVER holds everything; tick, hits and pause are ignored.
    tick = 1'b1; hits = 4'b1111; cyc();
    tick = 1'b1; pause = 1'b1; cyc();
    chk("over_rows",  rows_out, 32'hF000_F000);
    chk("over_state", 32'(state), 32'd3);
    chk("over_score", 32'(score), 32'd13);
    chk("over_miss",  32'(misses), 32'd15);
    chk("over_take",  32'(rand_take), 32'd0);

    start = 1'b1; cyc();
    chk_zero("over_start");

    // Pause freezes rows, counters and the spawn phase.
    start = 1'b1; cyc();
    rand_in = 4'b0101; tick = 1'b1; cyc();
    chk("p_take0", 32'(rand_take), 32'd1);
    chk("p_rows0", rows_out, 32'h5000_0000);
    pause = 1'b1; cyc();
    chk("p_state", 32'(state), 32'd2);
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1; hits = 4'b1111; cyc();
      chk($sformatf("p_take%0d", k + 1), 32'(rand_take), 32'd0);
    end
    chk("p_rows",  rows_out, 32'h5000_0000);
    chk("p_score", 32'(score), 32'd0);
    chk("p_combo", 32'(combo), 32'd0);
    chk("p_miss",  32'(misses), 32'd0);
    pause = 1'b1; cyc();
    chk("resume_state", 32'(state), 32'd1);

    // Tick together with pause: shift happens, then PAUSE.
    tick = 1'b1; pause = 1'b1; cyc();
    chk("tp_state", 32'(state), 32'd2);
    chk("tp_rows",  rows_out, 32'h0500_0000);
    pause = 1'b1; cyc();
    // Spawn phase resumes where it stopped: next spawn is the third tick.
    ticks(2);
    chk("ph_take2", 32'(rand_take), 32'd0);
    tick = 1'b1; cyc();
    chk("ph_take3", 32'(rand_take), 32'd1);
    chk("ph_rows",  rows_out, 32'h5000_5000);

    // Reset in the middle of PLAY.
    reset = 1'b1; cyc();
    reset = 1'b0;
    chk_zero("mid_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
